spectro_frame_packer: RTL and testbench
=======================================

# spectro_frame_packer

- Downstream stage of the spectrogram extractor's filter bank, inside `tt_um_Coline3003_top`.
- Integrates per-band magnitudes over a fixed number of sample periods into one spectrogram column.
- Snapshots the column, then streams it out as bytes (header + one byte per band) over a valid/ready handshake toward `uo_out`.
- Accumulation of the next frame overlaps transmission of the current one.

## Interface
Parameters:
- `NUM_BANDS`, 8, number of filter-bank bands (2..16).
- `MAG_W`, 12, width of unsigned input magnitude.
- `FRAME_LEN`, 64, sample periods per frame; power of two, at least 2.
- `ACC_W` (derived, localparam) = `MAG_W + $clog2(FRAME_LEN)` (18 by default).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable; when low, all state holds.
- `in_valid` in 1: magnitude beat present.
- `in_band` in 4: band index of beat.
- `in_mag` in `MAG_W`: unsigned magnitude.
- `in_last` in 1: qualifies `in_valid`; marks the last beat of a sample period.
- `out_valid` out 1: output byte valid.
- `out_ready` in 1: consumer accepts the byte.
- `out_data` out 8: output byte.
- `out_last` out 1: high on the final byte of a frame.
- `overrun` out 1: sticky flag, set when a frame was dropped.

## Operation
- One `ACC_W`-bit accumulator per band. On a cycle with `in_valid && ena`: `acc[in_band] += in_mag`.
  - Beats with `in_band >= NUM_BANDS` are ignored for accumulation; `in_last` on such a beat still counts.
  - Accumulators cannot overflow, because `ACC_W` is sized for `FRAME_LEN` full-scale beats per band.
  - Multiple beats to the same band within one sample period are summed.
- Sample counter `scnt` (`$clog2(FRAME_LEN)` bits) increments on `in_valid && in_last`.
- Frame end: `in_valid && in_last` with `scnt == FRAME_LEN-1`. On that edge:
  - `scnt` wraps to 0.
  - Every accumulator is cleared to 0.
  - The snapshot includes the current beat's magnitude.
  - If the output FSM can accept (see below), the final accumulator values are copied into the snapshot buffer. Otherwise the frame is dropped and `overrun` is set to 1.
- Output FSM states:
  - `O_IDLE`: `out_valid=0`. Goes to `O_HDR` on snapshot capture.
  - `O_HDR`: `out_data = {4'hA, fcnt[3:0]}`. Goes to `O_BAND` with `bidx=0` on handshake.
  - `O_BAND`: `out_data = enc(snap[bidx])`. On handshake, `bidx++`. On `bidx == NUM_BANDS-1`, asserts `out_last` and returns to `O_IDLE`; `fcnt` increments there (4-bit wrap 15→0).
- The FSM can accept a snapshot when it is in `O_IDLE`, or when the last band byte is handshaking in the same cycle. In the second case it goes directly to `O_HDR`, with no idle cycle.
- Dropped frames do not increment `fcnt`.
- Encoding `enc(a)` (default): `a[ACC_W-1 -: 8]`, the top 8 bits.
- `overrun` is cleared only by reset.

## Timing
- Reset values: `out_valid=0`, `out_data=0x00`, `out_last=0`, `overrun=0`, FSM in `O_IDLE`, accumulators 0, `scnt=0`, `fcnt=0`, `bidx=0`.
- Asserting reset mid-frame or mid-transmission aborts immediately; all outputs take their reset values asynchronously.
- `out_data` and `out_last` are registered. They stay stable while `out_valid && !out_ready`.
- `out_valid` never drops before the handshake completes.
- Latency: header valid 1 cycle after the frame-end edge. A full frame drains in `NUM_BANDS+1` cycles when `out_ready` stays at 1.
- `ena=0` freezes accumulation, counters, the FSM and the handshake. Outputs hold their values, and inputs are ignored.

## Configuration
- `SPECTRO_LOG_EN` defined: `enc(a)` becomes a log-style byte `{p[4:0], m[2:0]}`.
  - `p` = 1 + index of the leading one of `a`.
  - `m` = the 3 bits below the leading one, zero-padded when fewer than 3 exist.
  - `a == 0` encodes as 0x00.
- `SPECTRO_LOG_EN` undefined: linear top-8-bit truncation. No log logic is synthesized.

## Test plan
Default parameters.
- Full scale: every band gets `in_mag=0xFFF` for 64 sample periods, `out_ready=1` → bytes 0xA0, then 8×0xFF. `out_last` is high on the 9th byte only.
- Single band: band 3 gets `in_mag=0x010` for 64 periods, other bands get 0 → accumulator 0x400.
  - Linear: 0xA0, then bytes 0x00,0x00,0x00,0x01,0x00,0x00,0x00,0x00.
  - With `SPECTRO_LOG_EN`: band 3 byte = 0x58.
- Backpressure: `out_ready=0` for 5 cycles while the header is valid, then 1 → header 0xA0 is held stable for all 6 cycles. No bytes are lost or duplicated, and `fcnt` reaches 1 after the frame.
- Overrun: `out_ready=0` until two frames complete → `overrun=1`. On release exactly one frame (header 0xA0) is emitted, and the next emitted frame's header is 0xA1.
- Back-to-back boundary: frame end coincides with the handshake of the last band byte → the next header is valid on the following cycle with no idle gap, and `overrun` stays 0.
- Reset and enable: `rst_n=0` during band byte 4 → `out_valid=0` immediately. The next frame's header is 0xA0, with accumulators starting from 0. Holding `ena=0` for 10 cycles mid-frame leaves all outputs unchanged.

Source files
------------

// File: rtl/spectro_frame_packer.sv
// rtl/spectro_frame_packer.sv - per-band frame integrator and byte-stream packer
// Optional feature macro: SPECTRO_LOG_EN (log-style band byte encoding instead of top-8-bit truncation)
// Ports:
//   clk, rst_n                               clock, asynchronous active-low reset
//   ena                                      global enable; all state holds while low
//   in_valid, in_band, in_mag, in_last       magnitude beats from the filter bank
//   out_valid, out_ready, out_data, out_last byte stream: header {0xA, fcnt} then one byte per band
//   overrun                                  sticky; a completed frame was dropped
module spectro_frame_packer #(
  parameter int NUM_BANDS = 8,
  parameter int MAG_W     = 12,
  parameter int FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [3:0]       in_band,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             overrun
);

  localparam int SC_W  = $clog2(FRAME_LEN);
  localparam int ACC_W = MAG_W + SC_W;
  localparam logic [SC_W-1:0] SC_END = SC_W'(FRAME_LEN - 1);
  localparam logic [3:0]      B_LAST = 4'(NUM_BANDS - 1);

  typedef enum logic [1:0] {O_IDLE, O_HDR, O_BAND} o_state_t;

  function automatic logic [7:0] enc(input logic [ACC_W-1:0] a);
`ifdef SPECTRO_LOG_EN
    logic [ACC_W-1:0] norm;
    logic [4:0]       p;
    norm = '0;
    p    = '0;
    // Highest set bit wins; shifting it to the MSB leaves the mantissa
    // bits right below it, zero-filled when the leading one is near bit 0.
    for (int i = 0; i < ACC_W; i++) begin
      if (a[i]) begin
        p    = 5'(i + 1);
        norm = a << (ACC_W - 1 - i);
      end
    end
    enc = {p, norm[ACC_W-2 -: 3]};
`else
    enc = a[ACC_W-1 -: 8];
`endif
  endfunction

  logic [ACC_W-1:0] r_acc  [NUM_BANDS];
  logic [ACC_W-1:0] r_snap [NUM_BANDS];
  logic [SC_W-1:0]  r_scnt;
  logic [3:0]       r_fcnt;
  logic [3:0]       r_bidx;
  o_state_t         r_state;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_overrun;

  logic             w_beat;
  logic             w_frame_end;
  logic             w_hs;
  logic             w_last_hs;
  logic             w_can_accept;
  logic             w_capture;
  logic [ACC_W-1:0] w_mag_ext;
  o_state_t         w_state_nxt;
  logic [3:0]       w_bidx_nxt;
  logic [3:0]       w_fcnt_nxt;
  logic [3:0]       w_load_idx;
  logic             w_load_band;
  logic [ACC_W-1:0] w_load_val;
  logic [7:0]       w_data_nxt;
  logic             w_last_nxt;

  assign w_mag_ext    = {{SC_W{1'b0}}, in_mag};
  assign w_beat       = ena && in_valid;
  assign w_frame_end  = w_beat && in_last && (r_scnt == SC_END);
  assign w_hs         = ena && out_valid && out_ready;
  assign w_last_hs    = (r_state == O_BAND) && w_hs && (r_bidx == B_LAST);
  // A new snapshot may land while the last band byte leaves: snap is no longer needed.
  assign w_can_accept = (r_state == O_IDLE) || w_last_hs;
  assign w_capture    = w_frame_end && w_can_accept;

  assign out_valid = (r_state != O_IDLE);
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign overrun   = r_overrun;

  // Accumulators, sample counter, snapshot and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_acc[b]  <= '0;
        r_snap[b] <= '0;
      end
      r_scnt    <= '0;
      r_overrun <= 1'b0;
    end else if (w_beat) begin
      if (in_last) begin
        r_scnt <= r_scnt + 1'b1;
      end
      for (int b = 0; b < NUM_BANDS; b++) begin
        if (w_frame_end) begin
          r_acc[b] <= '0;
          // Snapshot includes the frame-ending beat itself.
          if (w_can_accept) begin
            r_snap[b] <= r_acc[b] + ((in_band == 4'(b)) ? w_mag_ext : '0);
          end
        end else if (in_band == 4'(b)) begin
          r_acc[b] <= r_acc[b] + w_mag_ext;
        end
      end
      if (w_frame_end && !w_can_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Output FSM state and registered output bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= O_IDLE;
      r_bidx     <= '0;
      r_fcnt     <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else if (ena) begin
      r_state    <= w_state_nxt;
      r_bidx     <= w_bidx_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_out_data <= w_data_nxt;
      r_out_last <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bidx_nxt  = r_bidx;
    w_fcnt_nxt  = r_fcnt;
    w_data_nxt  = r_out_data;
    w_last_nxt  = r_out_last;
    w_load_idx  = '0;
    w_load_band = 1'b0;
    w_load_val  = '0;

    case (r_state)
      O_IDLE: begin
      end
      O_HDR: begin
        if (w_hs) begin
          w_state_nxt = O_BAND;
          w_bidx_nxt  = '0;
          w_load_idx  = '0;
          w_load_band = 1'b1;
        end
      end
      O_BAND: begin
        if (w_hs) begin
          if (r_bidx == B_LAST) begin
            w_state_nxt = O_IDLE;
            w_fcnt_nxt  = r_fcnt + 1'b1;
            w_last_nxt  = 1'b0;
          end else begin
            w_bidx_nxt  = r_bidx + 1'b1;
            w_load_idx  = r_bidx + 1'b1;
            w_load_band = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = O_IDLE;
      end
    endcase

    // Header carries the post-increment count when a frame finishes in the same cycle.
    if (w_capture) begin
      w_state_nxt = O_HDR;
      w_data_nxt  = {4'hA, w_fcnt_nxt};
      w_last_nxt  = 1'b0;
    end

    for (int b = 0; b < NUM_BANDS; b++) begin
      if (w_load_idx == 4'(b)) begin
        w_load_val = r_snap[b];
      end
    end
    if (w_load_band) begin
      w_data_nxt = enc(w_load_val);
      w_last_nxt = (w_load_idx == B_LAST);
    end
  end

endmodule

// File: tb/tb_spectro_frame_packer.sv
// tb/tb_spectro_frame_packer.sv - randomized self-checking bench for spectro_frame_packer
module tb_spectro_frame_packer;

  localparam int NB = 8;
  localparam int MW = 12;
  localparam int FL = 64;
  localparam int AW = MW + $clog2(FL);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_band = '0;
  logic [MW-1:0] in_mag = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          overrun;

  int total = 0;
  int bad = 0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  int m_fcnt = 0;
  bit g_rnd = 1'b0;
  bit g_stall_last = 1'b0;

  always #5 clk = ~clk;

  spectro_frame_packer #(.NUM_BANDS(NB), .MAG_W(MW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_band(in_band), .in_mag(in_mag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .overrun(overrun)
  );

  always @(negedge clk)
    if (rst_n && ena && out_valid && out_ready) got.push_back({out_last, out_data});

  function automatic logic [7:0] enc_m(input longint s);
`ifdef SPECTRO_LOG_EN
    int k;
    if (s == 0) return 8'h00;
    k = 0;
    while ((s >> (k + 1)) != 0) k++;
    return {5'(k + 1), 3'(((s << 3) >> k) & 7)};
`else
    return 8'(s >> (AW - 8));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (g_rnd) out_ready = 1'($urandom_range(0, 1));
    if (g_stall_last && out_valid && out_last) out_ready = 1'b0;
  endtask

  task automatic beat(input int bd, input logic [MW-1:0] mg, input bit lst, input bit gaps);
    if (gaps && $urandom_range(0, 7) == 0) begin
      step();
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_band  = 4'($urandom_range(0, 15));
      in_mag   = MW'($urandom);
    end
    step();
    in_valid = 1'b1;
    in_band  = 4'(bd);
    in_mag   = mg;
    in_last  = lst;
  endtask

  // kind 0: full scale, 1: band 3 only at 0x010, 2: random with gaps and stray beats
  task automatic run_frame(input int kind, input bit drop, input bit chk_lat, input bit b2b);
    longint        sums[NB];
    logic [MW-1:0] mg;
    logic [7:0]    hdr;
    int            xb;
    bit            has_x;
    for (int b = 0; b < NB; b++) sums[b] = 0;
    g_stall_last = b2b;
    for (int p = 0; p < FL; p++) begin
      has_x = (kind == 2) && ($urandom_range(0, 3) == 0);
      for (int b = 0; b < NB; b++) begin
        case (kind)
          0:       mg = '1;
          1:       mg = (b == 3) ? MW'(16) : '0;
          default: mg = MW'($urandom_range(0, 2047));
        endcase
        sums[b] += mg;
        beat(b, mg, !has_x && (b == NB - 1), kind == 2);
      end
      if (has_x) begin
        xb = $urandom_range(0, 15);
        mg = MW'($urandom_range(0, 2047));
        if (xb < NB) sums[xb] += mg;
        beat(xb, mg, 1'b1, 1'b1);
      end
    end
    if (b2b) out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    g_stall_last = 1'b0;
    if (!drop) begin
      hdr = {4'hA, 4'(m_fcnt)};
      if (chk_lat) begin
        chk("lat_valid", out_valid, 1);
        chk("lat_hdr", out_data, hdr);
        chk("lat_last", out_last, 0);
      end
      exp_q.push_back({1'b0, hdr});
      for (int b = 0; b < NB; b++) exp_q.push_back({b == NB - 1, enc_m(sums[b])});
      m_fcnt++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    g_rnd = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((got.size() < exp_q.size() || out_valid === 1'b1) && n < 2000) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 2000), 1);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    ena = 1'b1;
    g_rnd = 1'b0;
    g_stall_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
    m_fcnt = 0;
  endtask

  initial begin
    ena = 1'b1;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovr", overrun, 0);
    do_reset();

    run_frame(0, 0, 1, 0);
    drain("full");
    run_frame(1, 0, 0, 0);
    drain("single");

    g_rnd = 1'b1;
    repeat (3) run_frame(2, 0, 0, 0);
    drain("rand");

    do_reset();
    out_ready = 1'b0;
    run_frame(2, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_hdr", {out_last, out_data}, 9'h0A0);
      step();
    end
    out_ready = 1'b1;
    chk("bp_valid6", out_valid, 1);
    chk("bp_hdr6", {out_last, out_data}, 9'h0A0);
    drain("bp");
    run_frame(2, 0, 1, 0);
    drain("bp_next");

    do_reset();
    out_ready = 1'b0;
    run_frame(2, 0, 0, 0);
    chk("ovr_pre", overrun, 0);
    run_frame(2, 1, 0, 0);
    chk("ovr_set", overrun, 1);
    drain("ovr");
    run_frame(2, 0, 1, 0);
    drain("ovr_next");
    chk("ovr_sticky", overrun, 1);

    do_reset();
    out_ready = 1'b1;
    run_frame(0, 0, 0, 0);
    run_frame(1, 0, 1, 1);
    chk("b2b_ovr", overrun, 0);
    drain("b2b");

    run_frame(2, 0, 0, 0);
    step();
    step();
    step();
    ena = 1'b0;
    in_valid = 1'b1;
    in_last = 1'b1;
    in_mag = '1;
    for (int i = 0; i < 10; i++) begin
      in_band = 4'($urandom_range(0, 15));
      step();
      chk("ena_valid", out_valid, 1);
      chk("ena_byte", {out_last, out_data}, exp_q[got.size()]);
      chk("ena_ovr", overrun, 0);
    end
    ena = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    drain("ena");
    run_frame(1, 0, 0, 0);
    drain("ena_next");

    run_frame(2, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      in_valid = 1'b1;
      in_band = 4'd0;
      in_mag = '1;
      in_last = 1'b1;
    end
    chk("rm_byte4", {out_last, out_data}, exp_q[5]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", out_valid, 0);
    chk("rm_data", out_data, 0);
    chk("rm_last", out_last, 0);
    do_reset();
    run_frame(1, 0, 1, 0);
    drain("rm_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
